// File: rtl/alu_arbiter_if.sv
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundles the signals around alu_arbiter: the execute-unit
//                and address-unit req/gnt/done handshakes and the operand,
//                result and flag lines to the shared 8-bit ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
  // Execute requester
  logic        exe_req;
  logic [3:0]  exe_op;
  logic [7:0]  exe_a;
  logic [7:0]  exe_b;
  logic        p_c;
  logic        p_v;
  logic        exe_gnt;
  logic        exe_done;
  logic [8:0]  exe_f;
  logic [3:0]  exe_nvzc;

  // Address requester
  logic        adr_req;
  logic [15:0] adr_base;
  logic [7:0]  adr_idx;
  logic        adr_gnt;
  logic        adr_done;
  logic [15:0] adr_sum;
  logic        adr_page_cross;

  // Shared ALU
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic        alu_carry_in;
  logic        alu_overflow_in;
  logic [8:0]  alu_f;
  logic        alu_n;
  logic        alu_v;
  logic        alu_z;
  logic        alu_c;

  // Arbiter view
  modport slave (
    input  exe_req, exe_op, exe_a, exe_b, p_c, p_v,
    input  adr_req, adr_base, adr_idx,
    input  alu_f, alu_n, alu_v, alu_z, alu_c,
    output exe_gnt, exe_done, exe_f, exe_nvzc,
    output adr_gnt, adr_done, adr_sum, adr_page_cross,
    output alu_a, alu_b, alu_op, alu_carry_in, alu_overflow_in
  );

  // Requester / ALU view
  modport master (
    output exe_req, exe_op, exe_a, exe_b, p_c, p_v,
    output adr_req, adr_base, adr_idx,
    output alu_f, alu_n, alu_v, alu_z, alu_c,
    input  exe_gnt, exe_done, exe_f, exe_nvzc,
    input  adr_gnt, adr_done, adr_sum, adr_page_cross,
    input  alu_a, alu_b, alu_op, alu_carry_in, alu_overflow_in
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational 8-bit ALU between the execute unit
//                (arithmetic/logic/shift ops) and the address unit (16-bit
//                base+index with page-cross fix-up). Round-robin on ties,
//                registered ALU drive, registered results and done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_arbiter_if.slave    bus
);

  localparam logic [3:0] C_ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] C_ALU_OP_INC  = 4'h5;
  localparam logic [3:0] C_ALU_OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXE    = 2'd1,
    S_ADR_LO = 2'd2,
    S_ADR_HI = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_adr;     // 1: address unit received the most recent grant
  logic [7:0]  r_base_hi;      // high byte of the base, needed for the fix-up cycle
  logic [7:0]  r_lo;           // low byte of the effective address

  logic        r_exe_done;
  logic [8:0]  r_exe_f;
  logic [3:0]  r_exe_nvzc;
  logic        r_adr_done;
  logic [15:0] r_adr_sum;
  logic        r_adr_page_cross;

  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_alu_carry_in;
  logic        r_alu_overflow_in;

  logic        w_idle;
  logic        w_exe_gnt;
  logic        w_adr_gnt;

  // Grant decode: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_exe_gnt = w_idle & bus.exe_req & (~bus.adr_req | r_last_adr);
    w_adr_gnt = w_idle & bus.adr_req & (~bus.exe_req | ~r_last_adr);
  end

  assign bus.exe_gnt         = w_exe_gnt;
  assign bus.adr_gnt         = w_adr_gnt;
  assign bus.exe_done        = r_exe_done;
  assign bus.exe_f           = r_exe_f;
  assign bus.exe_nvzc        = r_exe_nvzc;
  assign bus.adr_done        = r_adr_done;
  assign bus.adr_sum         = r_adr_sum;
  assign bus.adr_page_cross  = r_adr_page_cross;
  assign bus.alu_a           = r_alu_a;
  assign bus.alu_b           = r_alu_b;
  assign bus.alu_op          = r_alu_op;
  assign bus.alu_carry_in    = r_alu_carry_in;
  assign bus.alu_overflow_in = r_alu_overflow_in;

  // Arbitration FSM: loads the ALU drive registers on entry to each state so
  // the ALU sees stable operands for the whole state, and captures its result
  // at the end of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_last_adr        <= 1'b0;
      r_base_hi         <= 8'h00;
      r_lo              <= 8'h00;
      r_exe_done        <= 1'b0;
      r_exe_f           <= 9'h000;
      r_exe_nvzc        <= 4'h0;
      r_adr_done        <= 1'b0;
      r_adr_sum         <= 16'h0000;
      r_adr_page_cross  <= 1'b0;
      r_alu_a           <= 8'h00;
      r_alu_b           <= 8'h00;
      r_alu_op          <= C_ALU_OP_PASS;
      r_alu_carry_in    <= 1'b0;
      r_alu_overflow_in <= 1'b0;
    end else begin
      r_exe_done <= 1'b0;
      r_adr_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_adr_gnt) begin
            // Low-byte add of the effective address
            r_state           <= S_ADR_LO;
            r_last_adr        <= 1'b1;
            r_base_hi         <= bus.adr_base[15:8];
            r_alu_op          <= C_ALU_OP_ADD;
            r_alu_a           <= bus.adr_base[7:0];
            r_alu_b           <= bus.adr_idx;
            r_alu_carry_in    <= 1'b0;
            r_alu_overflow_in <= 1'b0;
          end else if (w_exe_gnt) begin
            r_state           <= S_EXE;
            r_last_adr        <= 1'b0;
            r_alu_op          <= bus.exe_op;
            r_alu_a           <= bus.exe_a;
            r_alu_b           <= bus.exe_b;
            r_alu_carry_in    <= bus.p_c;
            r_alu_overflow_in <= bus.p_v;
          end
        end

        S_EXE: begin
          r_exe_f           <= bus.alu_f;
          r_exe_nvzc        <= {bus.alu_n, bus.alu_v, bus.alu_z, bus.alu_c};
          r_exe_done        <= 1'b1;
          r_state           <= S_IDLE;
          r_alu_op          <= C_ALU_OP_PASS;
          r_alu_a           <= 8'h00;
          r_alu_b           <= 8'h00;
          r_alu_carry_in    <= 1'b0;
          r_alu_overflow_in <= 1'b0;
        end

        S_ADR_LO: begin
          r_lo <= bus.alu_f[7:0];
          if (bus.alu_f[8]) begin
            // Carry out of the low byte: increment the high byte next cycle
            r_state           <= S_ADR_HI;
            r_alu_op          <= C_ALU_OP_INC;
            r_alu_a           <= r_base_hi;
            r_alu_b           <= 8'h00;
            r_alu_carry_in    <= 1'b0;
            r_alu_overflow_in <= 1'b0;
          end else begin
            r_adr_sum         <= {r_base_hi, bus.alu_f[7:0]};
            r_adr_page_cross  <= 1'b0;
            r_adr_done        <= 1'b1;
            r_state           <= S_IDLE;
            r_alu_op          <= C_ALU_OP_PASS;
            r_alu_a           <= 8'h00;
            r_alu_b           <= 8'h00;
            r_alu_carry_in    <= 1'b0;
            r_alu_overflow_in <= 1'b0;
          end
        end

        S_ADR_HI: begin
          // 8-bit increment wraps 0xFF to 0x00, giving the mod 2^16 sum
          r_adr_sum         <= {bus.alu_f[7:0], r_lo};
          r_adr_page_cross  <= 1'b1;
          r_adr_done        <= 1'b1;
          r_state           <= S_IDLE;
          r_alu_op          <= C_ALU_OP_PASS;
          r_alu_a           <= 8'h00;
          r_alu_b           <= 8'h00;
          r_alu_carry_in    <= 1'b0;
          r_alu_overflow_in <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Bench for alu_arbiter with a behavioural 6502-style ALU and
//                a queue-based scoreboard checked by a done monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 INC, 6 DEC,
  // 7 ROR, 8 ROL, 9 LSR, A ASL (shifts act on b), others pass a.
  logic [8:0] m_f;
  logic       m_c, m_v;
  always_comb begin
    m_f = 9'h000;
    m_c = bus.alu_carry_in;
    m_v = bus.alu_overflow_in;
    case (bus.alu_op)
      4'h0: begin
        m_f = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_carry_in};
        m_c = m_f[8];
        m_v = (bus.alu_a[7] == bus.alu_b[7]) && (m_f[7] != bus.alu_a[7]);
      end
      4'h1: begin
        m_f = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'h00, ~bus.alu_carry_in};
        m_c = ~m_f[8];
        m_v = (bus.alu_a[7] != bus.alu_b[7]) && (m_f[7] != bus.alu_a[7]);
      end
      4'h2: m_f = {1'b0, bus.alu_a & bus.alu_b};
      4'h3: m_f = {1'b0, bus.alu_a | bus.alu_b};
      4'h4: m_f = {1'b0, bus.alu_a ^ bus.alu_b};
      4'h5: m_f = {1'b0, bus.alu_a} + 9'd1;
      4'h6: m_f = {1'b0, bus.alu_a} - 9'd1;
      4'h7: begin m_f = {bus.alu_b[0], bus.alu_carry_in, bus.alu_b[7:1]}; m_c = bus.alu_b[0]; end
      4'h8: begin m_f = {bus.alu_b[7], bus.alu_b[6:0], bus.alu_carry_in}; m_c = bus.alu_b[7]; end
      4'h9: begin m_f = {bus.alu_b[0], 1'b0, bus.alu_b[7:1]};             m_c = bus.alu_b[0]; end
      4'hA: begin m_f = {bus.alu_b[7], bus.alu_b[6:0], 1'b0};             m_c = bus.alu_b[7]; end
      default: m_f = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_f = m_f;
  assign bus.alu_n = m_f[7];
  assign bus.alu_z = (m_f[7:0] == 8'h00);
  assign bus.alu_c = m_c;
  assign bus.alu_v = m_v;

  typedef struct { logic [8:0] f; logic [3:0] nvzc; int cyc; } exe_exp_t;
  typedef struct { logic [15:0] sum; logic pc; int cyc; } adr_exp_t;
  exe_exp_t exe_q[$];
  adr_exp_t adr_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: pops an expectation whenever a done pulse is seen
  always @(negedge clk) begin
    if (bus.exe_done) begin
      if (exe_q.size() == 0) begin
        chk("exe_unexpected_done", 32'd1, 32'd0);
      end else begin
        exe_exp_t e;
        e = exe_q.pop_front();
        chk("exe_f",       {23'd0, bus.exe_f},   {23'd0, e.f});
        chk("exe_nvzc",    {28'd0, bus.exe_nvzc}, {28'd0, e.nvzc});
        chk("exe_latency", cyc, e.cyc);
      end
    end
    if (bus.adr_done) begin
      if (adr_q.size() == 0) begin
        chk("adr_unexpected_done", 32'd1, 32'd0);
      end else begin
        adr_exp_t e;
        e = adr_q.pop_front();
        chk("adr_sum",        {16'd0, bus.adr_sum},        {16'd0, e.sum});
        chk("adr_page_cross", {31'd0, bus.adr_page_cross}, {31'd0, e.pc});
        chk("adr_latency",    cyc, e.cyc);
      end
    end
  end

  task automatic issue_exe(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic v, input logic [8:0] ef,
                           input logic [3:0] env, input bit push, output int gcyc);
    int budget;
    @(negedge clk);
    bus.exe_op = op; bus.exe_a = a; bus.exe_b = b; bus.p_c = c; bus.p_v = v;
    bus.exe_req = 1'b1;
    #1;
    budget = 0;
    while (!bus.exe_gnt && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    if (!bus.exe_gnt) begin
      chk("exe_gnt_timeout", 32'd0, 32'd1);
      gcyc = -1;
      bus.exe_req = 1'b0;
    end else begin
      gcyc = cyc;
      if (push) exe_q.push_back('{ef, env, cyc + 2});
      @(posedge clk); #1;
      bus.exe_req = 1'b0;
    end
  endtask

  task automatic issue_adr(input logic [15:0] base, input logic [7:0] idx,
                           input logic [15:0] esum, input logic epc,
                           input bit push, output int gcyc);
    int budget;
    @(negedge clk);
    bus.adr_base = base; bus.adr_idx = idx;
    bus.adr_req = 1'b1;
    #1;
    budget = 0;
    while (!bus.adr_gnt && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    if (!bus.adr_gnt) begin
      chk("adr_gnt_timeout", 32'd0, 32'd1);
      gcyc = -1;
      bus.adr_req = 1'b0;
    end else begin
      gcyc = cyc;
      if (push) adr_q.push_back('{esum, epc, cyc + (epc ? 3 : 2)});
      @(posedge clk); #1;
      bus.adr_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, ga0, ga1, ge0, ge1;
    bus.exe_req = 1'b0; bus.exe_op = 4'h0; bus.exe_a = 8'h00; bus.exe_b = 8'h00;
    bus.p_c = 1'b0; bus.p_v = 1'b0;
    bus.adr_req = 1'b0; bus.adr_base = 16'h0000; bus.adr_idx = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_exe_done", {31'd0, bus.exe_done}, 32'd0);
    chk("rst_adr_done", {31'd0, bus.adr_done}, 32'd0);
    chk("rst_exe_f",    {23'd0, bus.exe_f}, 32'd0);
    chk("rst_adr_sum",  {16'd0, bus.adr_sum}, 32'd0);
    chk("rst_alu_op",   {28'd0, bus.alu_op}, 32'hF);
    chk("rst_alu_a",    {24'd0, bus.alu_a}, 32'd0);
    rst_n = 1'b1;

    // Execute: ADC 0x50 + 0x50
    issue_exe(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 9'h0A0, 4'b1100, 1'b1, g);
    // Address: wrap, no cross, cross
    issue_adr(16'hFFFF, 8'h01, 16'h0000, 1'b1, 1'b1, g);
    issue_adr(16'h12F0, 8'h05, 16'h12F5, 1'b0, 1'b1, g);
    issue_adr(16'h12F0, 8'h20, 16'h1310, 1'b1, 1'b1, g);
    // SBC 0x00 - 0x01 with C=1; ROR 0x01 with C=1
    issue_exe(4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 9'h1FF, 4'b1000, 1'b1, g);
    issue_exe(4'h7, 8'h00, 8'h01, 1'b1, 1'b0, 9'h180, 4'b1001, 1'b1, g);
    repeat (4) @(negedge clk);
    chk("idle_alu_op", {28'd0, bus.alu_op}, 32'hF);
    chk("idle_alu_b",  {24'd0, bus.alu_b}, 32'd0);

    // Reset during ADR_HI aborts the operation
    issue_adr(16'h12F0, 8'h20, 16'h0000, 1'b0, 1'b0, g);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_adr_done",   {31'd0, bus.adr_done}, 32'd0);
    chk("abort_adr_sum",    {16'd0, bus.adr_sum}, 32'd0);
    chk("abort_page_cross", {31'd0, bus.adr_page_cross}, 32'd0);
    chk("abort_exe_f",      {23'd0, bus.exe_f}, 32'd0);
    chk("abort_alu_op",     {28'd0, bus.alu_op}, 32'hF);
    chk("abort_alu_a",      {24'd0, bus.alu_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue_adr(16'h12F0, 8'h05, 16'h12F5, 1'b0, 1'b1, g);

    // Contention from a fresh reset: adr, exe, adr, exe, back to back
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      begin
        issue_adr(16'h0100, 8'h10, 16'h0110, 1'b0, 1'b1, ga0);
        issue_adr(16'h2000, 8'hFF, 16'h20FF, 1'b0, 1'b1, ga1);
      end
      begin
        issue_exe(4'h2, 8'hF0, 8'h3C, 1'b0, 1'b1, 9'h030, 4'b0100, 1'b1, ge0);
        issue_exe(4'h4, 8'hAA, 8'hAA, 1'b1, 1'b0, 9'h000, 4'b0011, 1'b1, ge1);
      end
    join
    chk("rr_exe0_cycle", ge0, ga0 + 2);
    chk("rr_adr1_cycle", ga1, ga0 + 4);
    chk("rr_exe1_cycle", ge1, ga0 + 6);

    repeat (10) @(negedge clk);
    chk("exe_queue_drained", exe_q.size(), 32'd0);
    chk("adr_queue_drained", adr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit ALU between the execute unit, for ADC/SBC/logic/shift/INC/DEC, and the address unit, for 16-bit base+index effective-address calculation with page-cross fix-up. Each requester uses a req/gnt/done handshake. The arbiter latches operands, drives the ALU from registers, captures results and flags, and reports them. It sits between the control unit's requesters and the ALU instance in the 2A03 core.

## Interface
- No parameters; widths fixed by the 6502 datapath.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exe_req  in  1  execute request; held until exe_gnt
- exe_op  in  4  ALU operation code, 0x0–0xA, others = pass a
- exe_a, exe_b  in  8  operands
- p_c, p_v  in  1  current status C and V, sampled at grant
- exe_gnt  out  1  combinational accept strobe
- exe_done  out  1  registered 1-cycle result-valid pulse
- exe_f  out  9  result, bit 8 = raw carry/borrow
- exe_nvzc  out  4  {N,V,Z,C} from ALU
- adr_req  in  1  address request; held until adr_gnt
- adr_base  in  16  base address
- adr_idx  in  8  index (X/Y)
- adr_gnt  out  1  combinational accept strobe
- adr_done  out  1  registered 1-cycle pulse
- adr_sum  out  16  base + zero-extended idx, mod 2^16
- adr_page_cross  out  1  high byte was incremented; valid with adr_done
- alu_a, alu_b  out  8  ALU operands, registered
- alu_op  out  4  ALU operation, registered
- alu_carry_in, alu_overflow_in  out  1  ALU flag inputs, registered
- alu_f  in  9  ALU result
- alu_n, alu_v, alu_z, alu_c  in  1  ALU flags

## Operation
- FSM states: IDLE, EXE, ADR_LO, ADR_HI.
- IDLE: grants at most one request per cycle; gnt = IDLE & req & selected.
  - Only one req high: that requester wins.
  - Both high: round-robin; the requester not granted last wins. After reset, last = exe, so adr wins the first tie.
  - Operands and p_c/p_v are latched on the grant edge. A req dropped before grant is ignored.
- EXE:
  - Drives alu_op = exe_op, alu_a/alu_b = latched operands, carry_in = p_c, overflow_in = p_v.
  - At end of state: captures alu_f → exe_f and {alu_n,alu_v,alu_z,alu_c} → exe_nvzc; pulses exe_done; returns to IDLE.
- ADR_LO:
  - Drives alu_op = 0x0 (add), a = base[7:0], b = idx, carry_in = 0, overflow_in = 0.
  - At end of state: captures alu_f[7:0] as the low byte.
  - alu_f[8] = 0: adr_sum = {base[15:8], lo}, page_cross = 0, adr_done, → IDLE.
  - alu_f[8] = 1: → ADR_HI.
- ADR_HI:
  - Drives alu_op = 0x5 (increment), a = base[15:8], b = 0.
  - At end of state: adr_sum = {alu_f[7:0], lo}, page_cross = 1, adr_done, → IDLE.
  - Base 0xFFxx wraps to 0x00xx.
- ALU inputs when in IDLE or after done: alu_op = 0xF (pass), a = b = 0, carry_in = overflow_in = 0.
- Result outputs hold their last value until overwritten by the next done for that requester.
- Reset mid-operation: aborts. No done is issued; all outputs and the FSM return to reset values immediately.

## Timing
- Reset values: state IDLE, last = exe. All outputs 0 except alu_op = 0xF. exe_f, exe_nvzc, adr_sum and adr_page_cross are 0.
- Execute: gnt in cycle N, exe_done in cycle N+2 (latency 2).
- Address, no page cross: latency 2. Page cross: adr_done in cycle N+3.
- done is registered. The FSM is in IDLE during the done cycle, so a new grant is possible in that cycle.
- Maximum throughput: one execute op every 2 cycles.
- gnt and done of different requesters can coincide in the same cycle.
- No combinational path from alu_* inputs to any output. ALU inputs are stable for the whole EXE/ADR state; the ALU is combinational.

## Test plan
- Reset, then exe_req with op 0x0, a = 0x50, b = 0x50, p_c = 0, gnt at cycle N → exe_done at N+2 with exe_f = 0x0A0 and nvzc = {1,1,0,0}.
- adr_req with base 0x12F0, idx 0x05 → adr_done at N+2, sum 0x12F5, page_cross = 0. Then base 0x12F0, idx 0x20 → done at N+3, sum 0x1310, page_cross = 1.
- Base 0xFFFF, idx 0x01 → sum 0x0000, page_cross = 1, done at N+3.
- Both req held high continuously from reset → grants alternate adr, exe, adr, exe. No grant while busy; a new grant is issued in each done cycle.
- exe op 0x1, a = 0x00, b = 0x01, p_c = 1 → exe_f[7:0] = 0xFF and nvzc = {1,0,0,0}. Also op 0x7 (ROR), b = 0x01, p_c = 1 → exe_f[7:0] = 0x80 and C = 1.
- rst_n asserted during ADR_HI → no adr_done; outputs at reset values. A request after release completes normally.
